// File: rtl/mem_seq.sv
// Memory sequencer: arbitrates icache/dcache line requests onto a nibble-wide memory port.
// Every cache-facing burst is staged through an internal line buffer so that strobes never stall.
module mem_seq #(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_push,
    input  logic          d_pull,
    input  logic [PA-3:0] d_tag,
    input  logic [3:0]    d_dwrite,
    output logic          d_rstrobe,
    output logic          d_wstrobe,
    input  logic          i_pull,
    input  logic [PA-3:0] i_tag,
    output logic          i_wstrobe,
    output logic [3:0]    dread,
    output logic          mem_cmd_valid,
    input  logic          mem_cmd_ready,
    output logic          mem_we,
    output logic [PA-3:0] mem_addr,
    output logic [3:0]    mem_wdata,
    input  logic [3:0]    mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);

    localparam int BEATS = 2 * LINE_LENGTH;
    localparam int CW    = $clog2(BEATS);
    localparam int BW    = 4 * BEATS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        CMD     = 3'd2,
        WDATA   = 3'd3,
        RDATA   = 3'd4,
        PLAY    = 3'd5,
        GAP     = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   line_buf;
    logic            owner_q;
    logic            last_owner_q;
    logic            we_q;
    logic [PA-3:0]   tag_q;

    logic            d_req, i_req, grant_d, last_beat;
    logic [3:0]      cur_nib;

    assign d_req     = d_push | d_pull;
    assign i_req     = i_pull;
    // On contention the requester that was not served last time wins (owner 1 = dcache).
    assign grant_d   = (d_req && i_req) ? !last_owner_q : d_req;
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign cur_nib   = line_buf[{cnt_q, 2'b00} +: 4];

    always_comb begin
        state_d       = state_q;
        d_rstrobe     = 1'b0;
        d_wstrobe     = 1'b0;
        i_wstrobe     = 1'b0;
        dread         = 4'd0;
        mem_cmd_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = 4'd0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (d_req || i_req)
                    state_d = (grant_d && d_push) ? CAPTURE : CMD;
            end
            CAPTURE: begin
                d_rstrobe = 1'b1;
                if (last_beat)
                    state_d = CMD;
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                mem_we        = we_q;
                mem_addr      = tag_q;
                if (mem_cmd_ready)
                    state_d = we_q ? WDATA : RDATA;
            end
            WDATA: begin
                mem_wdata = cur_nib;
                if (mem_ready && last_beat)
                    state_d = GAP;
            end
            RDATA: begin
                if (mem_ready && last_beat)
                    state_d = PLAY;
            end
            PLAY: begin
                dread     = cur_nib;
                d_wstrobe = owner_q;
                i_wstrobe = !owner_q;
                if (last_beat)
                    state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // While reset is held the state register may still show a stale state; keep outputs quiet.
        if (reset) begin
            d_rstrobe     = 1'b0;
            d_wstrobe     = 1'b0;
            i_wstrobe     = 1'b0;
            dread         = 4'd0;
            mem_cmd_valid = 1'b0;
            mem_we        = 1'b0;
            mem_addr      = '0;
            mem_wdata     = 4'd0;
            busy          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_buf     <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            we_q         <= 1'b0;
            tag_q        <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (d_req || i_req) begin
                        owner_q      <= grant_d;
                        last_owner_q <= grant_d;
                        tag_q        <= grant_d ? d_tag : i_tag;
                        we_q         <= grant_d && d_push;
                        cnt_q        <= '0;
                    end
                end
                CAPTURE: begin
                    line_buf[{cnt_q, 2'b00} +: 4] <= d_dwrite;
                    cnt_q                         <= cnt_q + 1'b1;
                end
                CMD: begin
                    if (mem_cmd_ready)
                        cnt_q <= '0;
                end
                WDATA: begin
                    if (mem_ready)
                        cnt_q <= cnt_q + 1'b1;
                end
                RDATA: begin
                    if (mem_ready) begin
                        line_buf[{cnt_q, 2'b00} +: 4] <= mem_rdata;
                        cnt_q                         <= cnt_q + 1'b1;
                    end
                end
                PLAY: begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
